endec_job_scheduler: RTL and testbench
======================================

# endec_job_scheduler

Job-level controller in front of `endec`. It arbitrates encode and decode frame requests from two requesters round-robin and drives `endec` frame, configuration and `en` inputs for one job at a time. It captures the result when the matching done flag arrives and returns it through per-type valid/ready result ports. It also owns the code-rate/generator-polynomial configuration, the encoder state carried between consecutive encode frames, and a per-job timeout watchdog.

## Interface
- `GEN_POLY_W`, 21, width of the flat generator polynomial (max constraint length × max code rate)
- `STATE_W`, 6, encoder state width (max state register count)
- `TIMEOUT`, 4096, max cycles `o_en` stays high per job before abort; must be ≥ 2
- `sys_clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `i_cfg_we` in 1: configuration write strobe
- `i_cfg_code_rate` in 1: code-rate select to apply
- `i_cfg_gen_poly_flat` in GEN_POLY_W: polynomials to apply
- `i_enc_req_valid` / `o_enc_req_ready` in/out 1: encode request handshake
- `i_enc_req_frame` in 192: encoder input frame
- `i_dec_req_valid` / `o_dec_req_ready` in/out 1: decode request handshake
- `i_dec_req_frame` in 384: received frame to decode
- `o_en` out 1: `endec` enable
- `o_code_rate` out 1, `o_gen_poly_flat` out GEN_POLY_W: active configuration to `endec`
- `o_encoder_data_frame` out 192, `o_decoder_data_frame` out 384: job frame registers
- `o_prv_encoder_state` out STATE_W: carried encoder state
- `i_encoder_data` in 576, `i_encoder_done` in 1: `endec` encode result
- `i_decoder_data` in 128, `i_decoder_done` in 1: `endec` decode result
- `o_enc_res_valid` out 1, `i_enc_res_ready` in 1, `o_enc_res_data` out 576: encode result
- `o_dec_res_valid` out 1, `i_dec_res_ready` in 1, `o_dec_res_data` out 128: decode result
- `o_busy` out 1: FSM not in IDLE
- `o_timeout` out 1: one-cycle pulse on job abort

## Operation
- FSM has three states: IDLE, RUN, GAP. Reset enters IDLE.
- All outputs reset to 0: frames, results, config, prv state, `o_en`, valids, readies, `o_busy`, `o_timeout`.
- Configuration:
  - `i_cfg_we` in IDLE applies the new config that cycle.
  - Outside IDLE, the write is latched as pending; a later write overwrites it. Pending config is applied on entry to IDLE, before any grant can occur.
  - Every config apply clears `o_prv_encoder_state` to 0.
- Eligibility:
  - Encode is eligible when `i_enc_req_valid`=1 and `o_enc_res_valid`=0.
  - Decode is eligible under the same rule with its own valid signals.
  - Ready is asserted combinationally, in IDLE only, to at most one requester. There is no grant in a cycle where config is being applied.
- Arbitration:
  - If only one type is eligible, it wins.
  - If both are eligible, the type not granted last wins.
  - The last-grant register resets to "decode", so encode wins the first tie.
- Grant (valid∧ready): the frame is captured into the matching `o_*_data_frame`. The job type and the `o_code_rate` matching the job are latched. The FSM moves to RUN and the cycle counter clears to 0.
- RUN:
  - `o_en`=1 and the counter increments each cycle.
  - The done flag of the active type completes the job. The done flag of the other type is ignored.
  - On completion, the matching `o_*_data` is captured into the result register and its valid is set.
  - On an encode completion, `o_prv_encoder_state` ← captured frame[191:192−STATE_W]. Decode jobs never touch it.
  - Completion moves the FSM to GAP.
- Timeout:
  - If the counter reaches TIMEOUT−1 without the active done flag, the job aborts.
  - Abort pulses `o_timeout`, sets no result valid, clears `o_prv_encoder_state` to 0 if the job was an encode, and moves the FSM to GAP.
  - If done and timeout occur in the same cycle, done wins.
- GAP: `o_en`=0 for exactly one cycle, then the FSM moves to IDLE. This forces `endec` to restart between jobs.
- Results: valid holds, with data stable, until ready=1. The valid clears the cycle after valid∧ready.
- `rst` mid-job aborts immediately: all state returns to reset values and any pending config is discarded.

## Timing
- Grant handshake in cycle t gives `o_en`=1 from t+1.
- Active done sampled in cycle d gives result valid=1 and `o_en`=0 at d+1. The FSM is back in IDLE at d+2, which is the earliest next grant; the next `o_en` rises at d+3.
- Timeout: `o_en` is high for TIMEOUT cycles, t+1 through t+TIMEOUT. `o_timeout` pulses at t+TIMEOUT+1.
- Frame, config and prv-state outputs stay constant for the whole time `o_en`=1.

## Test plan
- Reset, then one encode request with frame=192'h…A5, then done at RUN cycle 10:
  - `o_en` is high for 10 cycles.
  - `o_enc_res_valid` rises with `o_enc_res_data`=`i_encoder_data`.
  - `o_prv_encoder_state`=frame[191:186].
- Both requests valid continuously with results drained every cycle: grants alternate enc, dec, enc, dec, and every pair of jobs is separated by ≥1 cycle with `o_en`=0.
- Encode result held with `i_enc_res_ready`=0 while both types request:
  - Only decode is granted.
  - Encode is granted in the first IDLE after the encode result is drained.
- Config written mid-RUN (rate=1, poly=21'h1ABCD):
  - `o_code_rate`/`o_gen_poly_flat` are unchanged until GAP→IDLE and update in the IDLE cycle.
  - No grant occurs in that cycle.
  - `o_prv_encoder_state`=0.
- TIMEOUT=16 with done never asserted:
  - `o_en` is high for 16 cycles, then `o_timeout` pulses once.
  - No result valid is set, prv state is 0, and the next job is accepted.
- `rst` asserted at RUN cycle 3 with `i_decoder_done` in the same cycle: all outputs are 0 the next cycle and no decode result is produced.

Source files
------------

// File: rtl/endec_job_scheduler.sv
// Job-level controller for endec: round-robin encode/decode arbitration, config ownership,
// carried encoder state, result buffering and a per-job timeout watchdog.
module endec_job_scheduler #(
  parameter int GEN_POLY_W = 21,
  parameter int STATE_W    = 6,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  i_cfg_we,
  input  logic                  i_cfg_code_rate,
  input  logic [GEN_POLY_W-1:0] i_cfg_gen_poly_flat,
  input  logic                  i_enc_req_valid,
  output logic                  o_enc_req_ready,
  input  logic [191:0]          i_enc_req_frame,
  input  logic                  i_dec_req_valid,
  output logic                  o_dec_req_ready,
  input  logic [383:0]          i_dec_req_frame,
  output logic                  o_en,
  output logic                  o_code_rate,
  output logic [GEN_POLY_W-1:0] o_gen_poly_flat,
  output logic [191:0]          o_encoder_data_frame,
  output logic [383:0]          o_decoder_data_frame,
  output logic [STATE_W-1:0]    o_prv_encoder_state,
  input  logic [575:0]          i_encoder_data,
  input  logic                  i_encoder_done,
  input  logic [127:0]          i_decoder_data,
  input  logic                  i_decoder_done,
  output logic                  o_enc_res_valid,
  input  logic                  i_enc_res_ready,
  output logic [575:0]          o_enc_res_data,
  output logic                  o_dec_res_valid,
  input  logic                  i_dec_res_ready,
  output logic [127:0]          o_dec_res_data,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic                    job_is_enc;
  logic                    last_dec;
  logic                    pend_valid;
  logic                    pend_rate;
  logic [GEN_POLY_W-1:0]   pend_poly;
  logic                    cfg_hold;

  logic enc_elig, dec_elig, can_grant, grant_enc, grant_dec;
  logic active_done, timeout_hit;

  assign enc_elig    = i_enc_req_valid && !o_enc_res_valid;
  assign dec_elig    = i_dec_req_valid && !o_dec_res_valid;
  // cfg_hold marks the IDLE cycle that shows a config applied on GAP exit; no grant then.
  assign can_grant   = !rst && (state == IDLE) && !i_cfg_we && !cfg_hold;
  assign active_done = job_is_enc ? i_encoder_done : i_decoder_done;
  assign timeout_hit = !active_done && (cnt == CNT_W'(TIMEOUT - 1));

  assign o_enc_req_ready = grant_enc;
  assign o_dec_req_ready = grant_dec;
  assign o_en            = (state == RUN);
  assign o_busy          = (state != IDLE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grant_enc  = 1'b0;
    grant_dec  = 1'b0;
    state_next = state;
    if (can_grant) begin
      grant_enc = enc_elig && (!dec_elig || last_dec);
      grant_dec = dec_elig && !grant_enc;
    end
    case (state)
      IDLE:    if (grant_enc || grant_dec) state_next = RUN;
      RUN:     if (active_done || timeout_hit) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      // NOTE: frame and result registers are reset too because they drive visible outputs.
      state                <= IDLE;
      cnt                  <= '0;
      job_is_enc           <= 1'b0;
      last_dec             <= 1'b1;
      pend_valid           <= 1'b0;
      pend_rate            <= 1'b0;
      pend_poly            <= '0;
      cfg_hold             <= 1'b0;
      o_code_rate          <= 1'b0;
      o_gen_poly_flat      <= '0;
      o_encoder_data_frame <= '0;
      o_decoder_data_frame <= '0;
      o_prv_encoder_state  <= '0;
      o_enc_res_valid      <= 1'b0;
      o_enc_res_data       <= '0;
      o_dec_res_valid      <= 1'b0;
      o_dec_res_data       <= '0;
      o_timeout            <= 1'b0;
    end else begin
      state     <= state_next;
      o_timeout <= 1'b0;
      cfg_hold  <= 1'b0;

      if (o_enc_res_valid && i_enc_res_ready) o_enc_res_valid <= 1'b0;
      if (o_dec_res_valid && i_dec_res_ready) o_dec_res_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (i_cfg_we) begin
            o_code_rate         <= i_cfg_code_rate;
            o_gen_poly_flat     <= i_cfg_gen_poly_flat;
            o_prv_encoder_state <= '0;
          end else if (grant_enc) begin
            o_encoder_data_frame <= i_enc_req_frame;
            job_is_enc           <= 1'b1;
            last_dec             <= 1'b0;
            cnt                  <= '0;
          end else if (grant_dec) begin
            o_decoder_data_frame <= i_dec_req_frame;
            job_is_enc           <= 1'b0;
            last_dec             <= 1'b1;
            cnt                  <= '0;
          end
        end
        RUN: begin
          if (i_cfg_we) begin
            pend_valid <= 1'b1;
            pend_rate  <= i_cfg_code_rate;
            pend_poly  <= i_cfg_gen_poly_flat;
          end
          if (active_done) begin
            if (job_is_enc) begin
              o_enc_res_valid     <= 1'b1;
              o_enc_res_data      <= i_encoder_data;
              o_prv_encoder_state <= o_encoder_data_frame[191 -: STATE_W];
            end else begin
              o_dec_res_valid <= 1'b1;
              o_dec_res_data  <= i_decoder_data;
            end
          end else if (timeout_hit) begin
            o_timeout <= 1'b1;
            if (job_is_enc) o_prv_encoder_state <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          // A write landing in GAP itself is newer than any pending one.
          if (i_cfg_we || pend_valid) begin
            o_code_rate         <= i_cfg_we ? i_cfg_code_rate : pend_rate;
            o_gen_poly_flat     <= i_cfg_we ? i_cfg_gen_poly_flat : pend_poly;
            o_prv_encoder_state <= '0;
            pend_valid          <= 1'b0;
            cfg_hold            <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_endec_job_scheduler.sv
// Self-checking bench for endec_job_scheduler: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a job-level behavioural model.
module tb_endec_job_scheduler;

  localparam int TMO = 16;
  localparam logic [575:0] ENC_PAT = {18{32'hDEADBEEF}};
  localparam logic [127:0] DEC_PAT = {4{32'hC0FFEE11}};

  logic         sys_clk = 1'b0;
  logic         rst;
  logic         cfg_we, cfg_rate;
  logic [20:0]  cfg_poly;
  logic         enc_valid, dec_valid, enc_ready, dec_ready;
  logic [191:0] enc_frame;
  logic [383:0] dec_frame;
  logic         en, code_rate, busy, tmo_pulse;
  logic [20:0]  gen_poly;
  logic [191:0] enc_frame_q;
  logic [383:0] dec_frame_q;
  logic [5:0]   prv;
  logic [575:0] enc_data;
  logic         enc_done, dec_done;
  logic [127:0] dec_data;
  logic         enc_res_valid, enc_res_ready, dec_res_valid, dec_res_ready;
  logic [575:0] enc_res_data;
  logic [127:0] dec_res_data;

  always #5 sys_clk = ~sys_clk;

  endec_job_scheduler #(.GEN_POLY_W(21), .STATE_W(6), .TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .i_cfg_we(cfg_we), .i_cfg_code_rate(cfg_rate), .i_cfg_gen_poly_flat(cfg_poly),
    .i_enc_req_valid(enc_valid), .o_enc_req_ready(enc_ready), .i_enc_req_frame(enc_frame),
    .i_dec_req_valid(dec_valid), .o_dec_req_ready(dec_ready), .i_dec_req_frame(dec_frame),
    .o_en(en), .o_code_rate(code_rate), .o_gen_poly_flat(gen_poly),
    .o_encoder_data_frame(enc_frame_q), .o_decoder_data_frame(dec_frame_q),
    .o_prv_encoder_state(prv),
    .i_encoder_data(enc_data), .i_encoder_done(enc_done),
    .i_decoder_data(dec_data), .i_decoder_done(dec_done),
    .o_enc_res_valid(enc_res_valid), .i_enc_res_ready(enc_res_ready), .o_enc_res_data(enc_res_data),
    .o_dec_res_valid(dec_res_valid), .i_dec_res_ready(dec_res_ready), .o_dec_res_data(dec_res_data),
    .o_busy(busy), .o_timeout(tmo_pulse)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Job-level model: phase flags plus elapsed RUN cycles of the current job.
  bit           m_run, m_gap, m_fresh, m_to, m_job_enc, m_last_enc;
  int           m_elapsed;
  bit           m_rate, m_pend, m_pend_rate;
  logic [20:0]  m_poly, m_pend_poly;
  logic [191:0] m_enc_frame;
  logic [383:0] m_dec_frame;
  logic [5:0]   m_prv;
  bit           m_enc_v, m_dec_v;
  logic [575:0] m_enc_res;
  logic [127:0] m_dec_res;
  bit           exp_eg, exp_dg;

  // Samples of the last cycle, for directed literal checks.
  bit s_enc_ready, s_dec_ready, s_en, s_to;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [575:0] rnd();
    logic [575:0] r;
    for (int i = 0; i < 18; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_run = 0; m_gap = 0; m_fresh = 0; m_to = 0; m_job_enc = 0; m_last_enc = 0;
    m_elapsed = 0; m_rate = 0; m_poly = '0; m_pend = 0; m_pend_rate = 0; m_pend_poly = '0;
    m_enc_frame = '0; m_dec_frame = '0; m_prv = '0;
    m_enc_v = 0; m_dec_v = 0; m_enc_res = '0; m_dec_res = '0;
  endtask

  task automatic apply_cfg(input bit r, input logic [20:0] p);
    m_rate = r; m_poly = p; m_prv = '0;
  endtask

  task automatic compare_all();
    bit idle, can, ee, de;
    idle   = !m_run && !m_gap;
    can    = !rst && idle && !cfg_we && !m_fresh;
    ee     = enc_valid && !m_enc_v;
    de     = dec_valid && !m_dec_v;
    exp_eg = can && ee && (!de || !m_last_enc);
    exp_dg = can && de && !exp_eg;
    check("enc_req_ready", enc_ready, exp_eg);
    check("dec_req_ready", dec_ready, exp_dg);
    check("en", en, m_run);
    check("busy", busy, m_run || m_gap);
    check("timeout", tmo_pulse, m_to);
    check("code_rate", code_rate, m_rate);
    check("gen_poly", gen_poly, m_poly);
    check("enc_frame", enc_frame_q, m_enc_frame);
    check("dec_frame", dec_frame_q, m_dec_frame);
    check("prv_state", prv, m_prv);
    check("enc_res_valid", enc_res_valid, m_enc_v);
    check("enc_res_data", enc_res_data, m_enc_res);
    check("dec_res_valid", dec_res_valid, m_dec_v);
    check("dec_res_data", dec_res_data, m_dec_res);
  endtask

  task automatic model_update();
    bit was_pend;
    if (rst) begin
      model_reset();
      return;
    end
    m_to    = 0;
    m_fresh = 0;
    if (m_enc_v && enc_res_ready) m_enc_v = 0;
    if (m_dec_v && dec_res_ready) m_dec_v = 0;
    if (!m_run && !m_gap) begin
      if (cfg_we) apply_cfg(cfg_rate, cfg_poly);
      else if (exp_eg) begin
        m_enc_frame = enc_frame; m_job_enc = 1; m_last_enc = 1; m_run = 1; m_elapsed = 0;
      end else if (exp_dg) begin
        m_dec_frame = dec_frame; m_job_enc = 0; m_last_enc = 0; m_run = 1; m_elapsed = 0;
      end
    end else if (m_run) begin
      if (cfg_we) begin
        m_pend = 1; m_pend_rate = cfg_rate; m_pend_poly = cfg_poly;
      end
      if (m_job_enc ? enc_done : dec_done) begin
        if (m_job_enc) begin
          m_enc_v = 1; m_enc_res = enc_data; m_prv = m_enc_frame[191:186];
        end else begin
          m_dec_v = 1; m_dec_res = dec_data;
        end
        m_run = 0; m_gap = 1;
      end else if (m_elapsed == TMO - 1) begin
        m_to = 1;
        if (m_job_enc) m_prv = '0;
        m_run = 0; m_gap = 1;
      end else begin
        m_elapsed++;
      end
    end else begin
      m_gap    = 0;
      was_pend = m_pend;
      if (cfg_we) apply_cfg(cfg_rate, cfg_poly);
      else if (was_pend) apply_cfg(m_pend_rate, m_pend_poly);
      if (cfg_we || was_pend) m_fresh = 1;
      m_pend = 0;
    end
  endtask

  // Inputs are set by the caller just after a falling edge; this compares and advances one clock.
  task automatic cycle();
    #1;
    compare_all();
    s_enc_ready = enc_ready; s_dec_ready = dec_ready; s_en = en; s_to = tmo_pulse;
    model_update();
    @(negedge sys_clk);
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_rate = 0; cfg_poly = '0;
    enc_valid = 0; enc_frame = '0; dec_valid = 0; dec_frame = '0;
    enc_data = ENC_PAT; enc_done = 0; dec_data = DEC_PAT; dec_done = 0;
    enc_res_ready = 0; dec_res_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cycle(); cycle(); rst = 0;
  endtask

  int en_cnt, to_cnt, enc_g, dec_g, ngr;
  bit got;
  logic [3:0] seq;
  logic [191:0] f;

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge sys_clk);
    model_reset();
    rst = 0;
    check("reset_en", en, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_enc_res_valid", enc_res_valid, 1'b0);
    check("reset_prv", prv, 6'h0);

    // Single encode job, done in its 10th RUN cycle.
    enc_valid = 1; enc_frame = {6'b101101, {178{1'b0}}, 8'hA5};
    cycle();
    check("first_grant_enc", s_enc_ready, 1'b1);
    enc_valid = 0; en_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      enc_done = (k == 10);
      cycle();
      en_cnt += s_en;
    end
    enc_done = 0;
    check("enc_job_en_cycles", en_cnt, 10);
    check("enc_job_res_valid", enc_res_valid, 1'b1);
    check("enc_job_res_data", enc_res_data, ENC_PAT);
    check("enc_job_prv", prv, 6'h2D);
    check("enc_job_en_low", en, 1'b0);
    enc_res_ready = 1; cycle(); enc_res_ready = 0; cycle();

    // Both requesters continuously, results drained every cycle: strict alternation.
    do_reset();
    enc_valid = 1; dec_valid = 1; enc_done = 1; dec_done = 1;
    enc_res_ready = 1; dec_res_ready = 1;
    ngr = 0; seq = '0;
    for (int c = 0; c < 30 && ngr < 4; c++) begin
      cycle();
      if (s_enc_ready || s_dec_ready) begin
        seq = {seq[2:0], s_enc_ready};
        ngr++;
      end
    end
    check("alternation_count", ngr, 4);
    check("alternation_order", seq, 4'b1010);

    // Held encode result blocks encode grants; decode keeps being served.
    do_reset();
    enc_valid = 1; dec_valid = 1; enc_done = 1; dec_done = 1; dec_res_ready = 1;
    enc_g = 0; dec_g = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      enc_g += s_enc_ready; dec_g += s_dec_ready;
    end
    check("held_enc_grants", enc_g, 1);
    check("held_dec_grants_ge4", dec_g >= 4, 1'b1);
    enc_res_ready = 1; cycle(); enc_res_ready = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (s_enc_ready || s_dec_ready) begin
        got = 1;
        check("after_drain_first_grant_enc", s_enc_ready, 1'b1);
      end
    end
    check("after_drain_grant_seen", got, 1'b1);

    // Config written mid-RUN is deferred to IDLE entry and blocks that cycle's grant.
    do_reset();
    enc_valid = 1; dec_valid = 1; enc_frame = rnd(); dec_frame = rnd();
    cycle();
    for (int k = 1; k <= 6; k++) begin
      cfg_we = (k == 3); cfg_rate = 1; cfg_poly = 21'h1ABCD; enc_done = (k == 6);
      cycle();
    end
    cfg_we = 0; enc_done = 0;
    check("cfg_gap_rate_old", code_rate, 1'b0);
    check("cfg_gap_poly_old", gen_poly, 21'h0);
    cycle();
    check("cfg_idle_rate_new", code_rate, 1'b1);
    check("cfg_idle_poly_new", gen_poly, 21'h1ABCD);
    check("cfg_idle_prv_zero", prv, 6'h0);
    cycle();
    check("cfg_cycle_no_grant", {s_enc_ready, s_dec_ready}, 2'b00);
    cycle();
    check("cfg_next_dec_grant", s_dec_ready, 1'b1);
    idle_inputs(); dec_done = 1; enc_res_ready = 1; dec_res_ready = 1;
    repeat (6) cycle();

    // Timeout abort after a completed encode left a nonzero carried state.
    idle_inputs();
    f = rnd(); f[191] = 1'b1;
    enc_valid = 1; enc_frame = f; cycle();
    enc_valid = 0; enc_done = 1; cycle();
    enc_done = 0; enc_res_ready = 1; cycle();
    enc_res_ready = 0; cycle();
    check("pre_timeout_prv", prv, f[191:186]);
    enc_valid = 1; enc_frame = rnd(); cycle();
    enc_valid = 0; en_cnt = 0; to_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      en_cnt += s_en; to_cnt += s_to;
    end
    check("timeout_en_cycles", en_cnt, TMO);
    check("timeout_pulses", to_cnt, 1);
    check("timeout_no_result", enc_res_valid, 1'b0);
    check("timeout_prv_zero", prv, 6'h0);
    enc_valid = 1; got = 0;
    for (int c = 0; c < 5 && !got; c++) begin
      cycle();
      got = s_enc_ready;
    end
    check("timeout_next_job_accepted", got, 1'b1);
    enc_valid = 0; enc_done = 1; enc_res_ready = 1;
    repeat (4) cycle();

    // Reset in RUN cycle 3 together with the decode done flag.
    do_reset();
    dec_valid = 1; dec_frame = rnd(); cycle();
    dec_valid = 0; cycle(); cycle();
    rst = 1; dec_done = 1; cycle();
    rst = 0; dec_done = 0;
    check("rst_mid_en", en, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_dec_res_valid", dec_res_valid, 1'b0);
    check("rst_mid_dec_frame", dec_frame_q, 384'h0);
    repeat (3) cycle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(499) == 0);
      cfg_we        = ($urandom_range(19) == 0);
      cfg_rate      = $urandom_range(1);
      cfg_poly      = 21'($urandom);
      enc_valid     = $urandom_range(1);
      dec_valid     = $urandom_range(1);
      enc_frame     = rnd();
      dec_frame     = {rnd(), rnd()};
      enc_data      = rnd();
      dec_data      = rnd();
      enc_done      = ($urandom_range(5) == 0);
      dec_done      = ($urandom_range(5) == 0);
      enc_res_ready = $urandom_range(1);
      dec_res_ready = $urandom_range(1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
